// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: turns a byte stream into a GMII Ethernet frame
// (preamble, SFD, payload, zero pad, CRC32 FCS, inter-frame gap).
module gmii_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME = 60,
  parameter bit ENABLE_PAD = 1'b1,
  parameter int IFG_CYCLES = 12
) (
  input  logic       gmii_txc,
  input  logic       rst_n,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic [7:0] gmii_td,
  output logic       underrun
);
  typedef enum logic [3:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, ABORT, DROP, IFG} state_t;
  state_t state;
  logic [31:0] crc, crc_data, crc_zero;
  logic [15:0] bcnt, bcnt_inc, cnt;
  logic pad_more;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  always_comb begin
    crc_data = crc_byte(crc, s_tdata);
    crc_zero = crc_byte(crc, 8'h00);
    bcnt_inc = &bcnt ? bcnt : bcnt + 16'd1;
    pad_more = ENABLE_PAD && (bcnt < 16'(MIN_FRAME));
  end
  always_ff @(posedge gmii_txc or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      s_tready   <= 1'b0;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      gmii_td    <= 8'h00;
      underrun   <= 1'b0;
      crc        <= '1;
      bcnt       <= '0;
      cnt        <= '0;
    end else begin
      underrun   <= 1'b0;
      gmii_tx_er <= 1'b0;
      case (state)
        IDLE:
          if (s_tvalid) begin
            state      <= PREAMBLE;
            gmii_tx_en <= 1'b1;
            gmii_td    <= 8'h55;
            cnt        <= 16'd1;
            crc        <= '1;
            bcnt       <= '0;
          end
        PREAMBLE:
          if (cnt == 16'(PREAMBLE_LEN)) begin
            state    <= SFD;
            gmii_td  <= 8'hD5;
            s_tready <= 1'b1;
          end else cnt <= cnt + 16'd1;
        // DATA with s_tready low is the cycle showing the tlast byte; decide pad vs FCS there
        SFD, DATA, PAD:
          if (s_tready && s_tvalid) begin
            state    <= DATA;
            gmii_td  <= s_tdata;
            crc      <= crc_data;
            bcnt     <= bcnt_inc;
            s_tready <= !s_tlast;
          end else if (s_tready) begin
            state      <= ABORT;
            s_tready   <= 1'b0;
            gmii_tx_er <= 1'b1;
            gmii_td    <= 8'hFF;
            underrun   <= 1'b1;
          end else if (pad_more) begin
            state   <= PAD;
            gmii_td <= 8'h00;
            crc     <= crc_zero;
            bcnt    <= bcnt_inc;
          end else begin
            state   <= FCS;
            gmii_td <= ~crc[7:0];
            crc     <= (~crc) >> 8;
            cnt     <= 16'd1;
          end
        FCS:
          if (cnt == 16'd4) begin
            state      <= IFG;
            gmii_tx_en <= 1'b0;
            gmii_td    <= 8'h00;
            cnt        <= 16'd1;
          end else begin
            gmii_td <= crc[7:0];
            crc     <= crc >> 8;
            cnt     <= cnt + 16'd1;
          end
        ABORT: begin
          state      <= DROP;
          gmii_tx_en <= 1'b0;
          gmii_td    <= 8'h00;
          s_tready   <= 1'b1;
        end
        DROP:
          if (s_tvalid && s_tlast) begin
            state    <= IFG;
            s_tready <= 1'b0;
            cnt      <= 16'd1;
          end
        IFG:
          if (cnt >= 16'(IFG_CYCLES)) state <= IDLE;
          else cnt <= cnt + 16'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb_gmii_tx_framer: table-driven and randomized frame checks against a
// byte-level frame model (table CRC32, whole-cycle expected trace).
module tb_gmii_tx_framer;
  localparam int PL = 7, MF = 60, IFG = 12;
  typedef logic [7:0] bq_t[$];
  typedef struct packed {logic en, er, ur, rdy; logic [7:0] td;} smp_t;
  typedef struct {int w; int kind; int len; int stall; int exp_en; logic [31:0] exp_fcs; string nm;} vec_t;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [7:0] tdata[2], td[2];
  logic tvalid[2], tlast[2], tready[2], en[2], er[2], ur[2];
  int checks = 0, errors = 0;
  bit log_on = 1'b0;
  smp_t lg0[$], lg1[$];
  smp_t ex[$];  // expected trace; rdy field means "s_tready must be 0 here"
  logic [31:0] ctab[256];

  always #4 clk = ~clk;

  gmii_tx_framer #(.PREAMBLE_LEN(PL), .MIN_FRAME(MF), .ENABLE_PAD(1'b1), .IFG_CYCLES(IFG)) u_pad (
    .gmii_txc(clk), .rst_n(rst_n), .s_tdata(tdata[0]), .s_tvalid(tvalid[0]), .s_tlast(tlast[0]),
    .s_tready(tready[0]), .gmii_tx_en(en[0]), .gmii_tx_er(er[0]), .gmii_td(td[0]), .underrun(ur[0]));
  gmii_tx_framer #(.PREAMBLE_LEN(PL), .MIN_FRAME(MF), .ENABLE_PAD(1'b0), .IFG_CYCLES(IFG)) u_nopad (
    .gmii_txc(clk), .rst_n(rst_n), .s_tdata(tdata[1]), .s_tvalid(tvalid[1]), .s_tlast(tlast[1]),
    .s_tready(tready[1]), .gmii_tx_en(en[1]), .gmii_tx_er(er[1]), .gmii_td(td[1]), .underrun(ur[1]));

  always @(posedge clk) begin
    #1;
    if (log_on) begin
      lg0.push_back(smp_t'({en[0], er[0], ur[0], tready[0], td[0]}));
      lg1.push_back(smp_t'({en[1], er[1], ur[1], tready[1], td[1]}));
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fcs_of(input bq_t b);
    logic [31:0] c = '1;
    foreach (b[i]) c = ctab[c[7:0] ^ b[i]] ^ (c >> 8);
    return ~c;
  endfunction

  function automatic bq_t mk(input int kind, input int len);
    bq_t q;
    string s = "123456789";
    for (int i = 0; i < len; i++)
      q.push_back(kind == 0 ? 8'(i) : kind == 1 ? 8'(s[i]) : 8'($urandom));
    return q;
  endfunction

  function automatic void push_e(input logic e, input logic r, input logic u, input logic z, input logic [7:0] d);
    ex.push_back(smp_t'({e, r, u, z, d}));
  endfunction

  task automatic expect_frame(input bq_t p, input bit pad, input int stall);
    bq_t body;
    logic [31:0] f;
    repeat (PL) push_e(1, 0, 0, 0, 8'h55);
    push_e(1, 0, 0, 0, 8'hD5);
    if (stall < 0) begin
      body = p;
      while (pad && body.size() < MF) body.push_back(8'h00);
      foreach (body[i]) push_e(1, 0, 0, 0, body[i]);
      f = fcs_of(body);
      for (int i = 0; i < 4; i++) push_e(1, 0, 0, 0, f[8*i +: 8]);
    end else begin
      for (int i = 0; i < stall; i++) push_e(1, 0, 0, 0, p[i]);
      push_e(1, 1, 1, 0, 8'hFF);
      repeat (p.size() - stall) push_e(0, 0, 0, 0, 8'h00);
    end
    repeat (IFG + 1) push_e(0, 0, 0, 1, 8'h00);
  endtask

  task automatic send(input int w, input bq_t p, input int stall);
    int idx = 0, cyc = 0;
    bit st = 1'b0;
    while (idx < p.size()) begin
      @(negedge clk);
      if (idx == stall && !st && tready[w]) begin
        tvalid[w] = 1'b0;
        st = 1'b1;
      end else begin
        tvalid[w] = 1'b1;
        tdata[w] = p[idx];
        tlast[w] = (idx == p.size() - 1);
      end
      if (tvalid[w] && tready[w]) idx++;
      if (++cyc > 3000) begin
        chk(1'b0, "send timeout", idx, p.size());
        break;
      end
    end
  endtask

  task automatic frame(input int w, input bq_t p, input int stall);
    expect_frame(p, w == 0, stall);
    send(w, p, stall);
  endtask

  task automatic begin_seq();
    lg0.delete();
    lg1.delete();
    ex.delete();
    log_on = 1'b1;
  endtask

  task automatic end_seq(input int w);
    @(negedge clk);
    tvalid[w] = 1'b0;
    tlast[w] = 1'b0;
    repeat (110) @(posedge clk);
    #2 log_on = 1'b0;
  endtask

  function automatic bq_t dummy_q();
    bq_t q;
    return q;
  endfunction

  task automatic get_log(input int w, output smp_t l[$]);
    if (w == 1) l = lg1;
    else l = lg0;
  endtask

  task automatic cmp(input int w, input string nm, input int exp_en, input int exp_ur);
    smp_t l[$];
    int s = -1, bad = -1, ne = 0, nu = 0, act = 0, exv = 0;
    get_log(w, l);
    foreach (l[i]) begin
      if (s < 0 && l[i].en) s = i;
      ne += int'(l[i].en);
      nu += int'(l[i].ur);
    end
    for (int i = 0; i < ex.size() && bad < 0; i++) begin
      if (s < 0 || s + i >= l.size()) bad = i;
      else if (l[s+i].en !== ex[i].en || l[s+i].er !== ex[i].er || l[s+i].ur !== ex[i].ur ||
               l[s+i].td !== ex[i].td || (ex[i].rdy && l[s+i].rdy !== 1'b0)) begin
        bad = i;
        act = int'(l[s+i]);
        exv = int'(ex[i]);
      end
    end
    chk(bad < 0, $sformatf("%s trace@%0d {en,er,ur,rdy,td}", nm, bad), act, exv);
    if (exp_en >= 0) chk(ne == exp_en, {nm, " tx_en cycles"}, ne, exp_en);
    if (exp_ur >= 0) chk(nu == exp_ur, {nm, " underrun pulses"}, nu, exp_ur);
  endtask

  task automatic last_fcs(input int w, output logic [31:0] r);
    smp_t l[$];
    get_log(w, l);
    r = '0;
    foreach (l[i]) if (l[i].en) r = {l[i].td, r[31:8]};
  endtask

  task automatic first_gap(input int w, output int g);
    smp_t l[$];
    int ph = 0;
    get_log(w, l);
    g = 0;
    foreach (l[i]) begin
      if (ph == 0 && l[i].en) ph = 1;
      else if (ph == 1 && !l[i].en) ph = 2;
      if (ph == 2 && l[i].en) ph = 3;
      if (ph == 2) begin
        g++;
        if (l[i].rdy) g += 1000;
      end
    end
  endtask

  initial begin
    vec_t v[$];
    bq_t p;
    logic [31:0] f;
    int g, w, n, len, st;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int j = 0; j < 8; j++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
      ctab[i] = c;
    end
    for (int k = 0; k < 2; k++) begin
      tvalid[k] = 1'b0;
      tlast[k] = 1'b0;
      tdata[k] = 8'h00;
    end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++)
      chk({en[k], er[k], ur[k], tready[k], td[k]} == 12'h0, $sformatf("reset state inst%0d", k),
          int'({en[k], er[k], ur[k], tready[k], td[k]}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    v.push_back('{0, 0, 64, -1, 76, 32'h0, "len64 0x00..0x3F"});
    v.push_back('{1, 1, 9, -1, 21, 32'hCBF43926, "nopad 123456789"});
    v.push_back('{0, 0, 14, -1, 72, 32'h0, "len14 padded"});
    v.push_back('{0, 0, 1, -1, 72, 32'h0, "len1 padded"});
    v.push_back('{0, 0, 59, -1, 72, 32'h0, "len59 padded"});
    v.push_back('{0, 0, 60, -1, 72, 32'h0, "len60 exact"});
    v.push_back('{0, 0, 61, -1, 73, 32'h0, "len61"});
    v.push_back('{1, 0, 1, -1, 13, 32'h0, "nopad len1"});
    v.push_back('{1, 0, 14, -1, 26, 32'h0, "nopad len14"});
    v.push_back('{0, 0, 30, 20, 29, 32'h0, "underrun after 20"});
    v.push_back('{0, 0, 5, 0, 9, 32'h0, "underrun at SFD"});
    v.push_back('{1, 0, 8, 7, 16, 32'h0, "underrun before last"});
    foreach (v[k]) begin
      p = mk(v[k].kind, v[k].len);
      begin_seq();
      frame(v[k].w, p, v[k].stall);
      end_seq(v[k].w);
      cmp(v[k].w, v[k].nm, v[k].exp_en, v[k].stall >= 0 ? 1 : 0);
      if (v[k].exp_fcs != 32'h0) begin
        last_fcs(v[k].w, f);
        chk(f == v[k].exp_fcs, {v[k].nm, " fcs bytes"}, int'(f), int'(v[k].exp_fcs));
      end
    end

    begin_seq();
    frame(0, mk(2, 64), -1);
    frame(0, mk(2, 20), -1);
    end_seq(0);
    cmp(0, "back-to-back", -1, 0);
    first_gap(0, g);
    chk(g == IFG + 1, "back-to-back gap (+1000 per s_tready high)", g, IFG + 1);

    begin_seq();
    frame(0, mk(2, 40), 25);
    frame(0, mk(2, 70), -1);
    end_seq(0);
    cmp(0, "abort then frame", -1, 1);
    first_gap(0, g);
    chk(g == 15 + IFG + 1 + 15000, "abort drop+ifg gap", g, 15 + IFG + 1 + 15000);

    repeat (12) begin
      w = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 3));
      begin_seq();
      repeat (n) begin
        len = int'($urandom_range(1, 100));
        st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
        frame(w, mk(2, len), st);
      end
      end_seq(w);
      cmp(w, $sformatf("random inst%0d", w), -1, -1);
    end

    @(negedge clk);
    tvalid[0] = 1'b1;
    tlast[0] = 1'b0;
    tdata[0] = 8'hA5;
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2;
    chk(en[0] === 1'b1, "pre-reset tx_en", int'(en[0]), 1);
    rst_n = 1'b0;
    #1;
    chk({en[0], er[0], ur[0], tready[0], td[0]} == 12'h0, "async reset mid-DATA",
        int'({en[0], er[0], ur[0], tready[0], td[0]}), 0);
    tvalid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    begin_seq();
    frame(0, mk(2, 64), -1);
    end_seq(0);
    cmp(0, "after reset", 76, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gmii_tx_framer.md
Name: gmii_tx_framer

Overview:
- Transmit MAC framing stage directly upstream of the RGMII PHY adapter's GMII transmit input.
- Accepts a byte-wide packet stream and produces a complete Ethernet frame on GMII: preamble, SFD, payload, zero padding to minimum length, CRC32 FCS, and inter-frame gap.
- Runs entirely in the GMII transmit clock domain (gmii_txc).

Parameters:
- PREAMBLE_LEN, 7: number of 0x55 bytes before the SFD (1..15).
- MIN_FRAME, 60: minimum payload bytes before FCS; shorter frames are zero-padded.
- ENABLE_PAD, 1: 1 enables padding; 0 sends payload unpadded.
- IFG_CYCLES, 12: idle cycles forced after each FCS or abort (>=1).

Ports:
- gmii_txc  in  1  transmit clock, 125 MHz; all logic on rising edge.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- s_tdata  in  8  payload byte (destination MAC first).
- s_tvalid  in  1  byte valid.
- s_tlast  in  1  last payload byte of frame.
- s_tready  out  1  byte accepted when s_tvalid & s_tready.
- gmii_tx_en  out  1  to PHY adapter.
- gmii_tx_er  out  1  to PHY adapter.
- gmii_td  out  8  to PHY adapter.
- underrun  out  1  one-cycle pulse on frame abort due to upstream starvation.

Behaviour:
- Reset (rst_n=0, async): state IDLE; gmii_tx_en=0, gmii_tx_er=0, gmii_td=0x00, s_tready=0, underrun=0; CRC=0xFFFFFFFF; byte and IFG counters=0. A mid-frame reset truncates the frame immediately with no FCS. After release, a new frame may start on the first cycle.
- All GMII outputs are registered. gmii_td=0x00 whenever gmii_tx_en=0.
- States: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, ABORT, DROP, IFG.
- IDLE: s_tready=0. If s_tvalid=1, go to PREAMBLE; the bus shows the first 0x55 on the next cycle. No data is consumed.
- PREAMBLE: bus shows 0x55 for PREAMBLE_LEN cycles, then 0xD5 for one cycle (SFD).
- s_tready rule: s_tready=1 during the SFD bus cycle and every DATA cycle, until the s_tlast beat is accepted. s_tready=0 in every other state.
- DATA: a byte accepted in cycle n appears on gmii_td in cycle n+1 with tx_en=1. Each accepted byte updates the CRC and increments a 16-bit byte count, which saturates at 0xFFFF.
- After s_tlast is accepted:
  - If ENABLE_PAD=1 and count<MIN_FRAME, go to PAD.
  - Otherwise go to FCS.
- PAD: emits 0x00 bytes, each included in the CRC, until count==MIN_FRAME, then goes to FCS.
- CRC32 definition: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, LSB-first per byte. FCS = ~CRC, sent least-significant byte first over 4 cycles. The CRC covers destination MAC through pad, and excludes preamble/SFD.
- FCS: after the 4th FCS byte, go to IFG.
- IFG: tx_en=0 for exactly IFG_CYCLES cycles, then IDLE. s_tvalid during IFG is ignored; the frame start is deferred.
- Underrun: if s_tvalid=0 during a cycle with s_tready=1 (SFD cycle or DATA):
  - next cycle: gmii_tx_en=1, gmii_tx_er=1, gmii_td=0xFF (ABORT, 1 cycle), underrun=1 for that cycle;
  - then DROP: s_tready=1, discard beats until s_tlast is accepted (no GMII activity);
  - then IFG. If the starved frame's last beat was already consumed, DROP is skipped.
- gmii_tx_er=0 in all states except ABORT.
- Back-to-back: the minimum gap from the last FCS byte to the next first preamble byte is IFG_CYCLES+1 cycles. The extra cycle is the IDLE detect cycle.
- s_tdata/s_tlast are ignored when s_tready=0.

Test Plan:
- 64-byte frame, bytes 0x00..0x3F, s_tvalid held high: tx_en high for 7+1+64+4=76 contiguous cycles. Bus shows 55×7, D5, 00..3F, then the 4 FCS bytes matching the reference CRC32 model. tx_er stays 0.
- ENABLE_PAD=0, payload ASCII "123456789": FCS bytes on bus are 0x26,0x39,0xF4,0xCB; tx_en high for 21 cycles.
- 14-byte frame, ENABLE_PAD=1: 46 0x00 pad bytes follow the payload. The total bytes after SFD are 64, and the FCS is computed over all 60 bytes.
- Deassert s_tvalid for one cycle after 20 accepted bytes, remaining beats up to tlast supplied afterwards:
  - next cycle shows tx_en=1, tx_er=1, td=0xFF, underrun=1;
  - remaining beats are consumed with no bus activity;
  - then 12 idle cycles.
- Two frames presented back-to-back: exactly 13 cycles with tx_en=0 between the last FCS byte and the next 0x55, and s_tready stays 0 throughout the gap.
- Assert rst_n=0 mid-DATA: outputs go to 0 asynchronously (same cycle). After release, a fresh frame transmits correctly with the correct CRC.
